// File: rtl/up_down_counter_param_if.sv
// Control/status bundle for up_down_counter_param: the counter is the slave,
// whoever drives the count commands is the master.
interface up_down_counter_param_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic             sat_mode;
    logic             clr_flags;
    logic [WIDTH-1:0] out;
    logic             wrap;
    logic             ovf;
    logic             unf;

    modport master (
        output en, up_down, load, load_val, limit, sat_mode, clr_flags,
        input  out, wrap, ovf, unf
    );

    modport slave (
        input  en, up_down, load, load_val, limit, sat_mode, clr_flags,
        output out, wrap, ovf, unf
    );
endinterface

// File: rtl/up_down_counter_param.sv
// Bounded up/down counter over 0..limit with load, enable, wrap pulse and sticky ovf/unf.
// Define UDC_SATURATE_EN to let sat_mode select saturate instead of wrap at the bounds.
module up_down_counter_param #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    up_down_counter_param_if.slave bus
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] out_r;
    logic             wrap_r;
    logic             ovf_r;
    logic             unf_r;

    logic [WIDTH-1:0] out_nxt_s;
    logic             wrap_nxt_s;
    logic             ovf_set_s;
    logic             unf_set_s;
    logic             sat_s;

`ifdef UDC_SATURATE_EN
    assign sat_s = bus.sat_mode;
`else
    assign sat_s = 1'b0;
`endif

    // Next count and boundary events; the bound is checked before stepping so no overflow occurs.
    always_comb begin
        out_nxt_s  = out_r;
        wrap_nxt_s = 1'b0;
        ovf_set_s  = 1'b0;
        unf_set_s  = 1'b0;
        if (bus.load) begin
            if (bus.load_val > bus.limit) begin
                out_nxt_s = bus.limit;
            end else begin
                out_nxt_s = bus.load_val;
            end
        end else if (bus.en) begin
            if (bus.up_down) begin
                if (out_r < bus.limit) begin
                    out_nxt_s = out_r + ONE;
                end else begin
                    wrap_nxt_s = 1'b1;
                    ovf_set_s  = 1'b1;
                    if (sat_s) begin
                        out_nxt_s = bus.limit;
                    end else begin
                        out_nxt_s = ZERO;
                    end
                end
            end else begin
                if (out_r == ZERO) begin
                    wrap_nxt_s = 1'b1;
                    unf_set_s  = 1'b1;
                    if (sat_s) begin
                        out_nxt_s = ZERO;
                    end else begin
                        out_nxt_s = bus.limit;
                    end
                end else if (out_r > bus.limit) begin
                    // limit was lowered underneath the count: snap back into range silently
                    out_nxt_s = bus.limit;
                end else begin
                    out_nxt_s = out_r - ONE;
                end
            end
        end else begin
            out_nxt_s = out_r;
        end
    end

    // State registers; a set event outranks a same-cycle clear of the sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r  <= ZERO;
            wrap_r <= 1'b0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
        end else begin
            out_r  <= out_nxt_s;
            wrap_r <= wrap_nxt_s;
            ovf_r  <= ovf_set_s | (ovf_r & ~bus.clr_flags);
            unf_r  <= unf_set_s | (unf_r & ~bus.clr_flags);
        end
    end

    assign bus.out  = out_r;
    assign bus.wrap = wrap_r;
    assign bus.ovf  = ovf_r;
    assign bus.unf  = unf_r;

endmodule

// File: tb/tb_up_down_counter_param.sv
// Self-checking bench for up_down_counter_param: directed scenarios plus random traffic
// checked every cycle against an integer reference model.
module tb_up_down_counter_param;

    localparam int WIDTH = 8;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    // reference model state
    int m_out;
    int m_wrap;
    int m_ovf;
    int m_unf;

    up_down_counter_param_if #(.WIDTH(WIDTH)) ifc ();

    up_down_counter_param #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int saturating_enabled();
`ifdef UDC_SATURATE_EN
        return int'(ifc.sat_mode);
`else
        return 0;
`endif
    endfunction

    // Model: what the counter must hold after the coming edge, from the current inputs.
    task automatic model_step();
        int lim;
        int ld;
        int sat;
        bit ev_o;
        bit ev_u;
        lim  = int'(ifc.limit);
        ld   = int'(ifc.load_val);
        sat  = saturating_enabled();
        ev_o = 1'b0;
        ev_u = 1'b0;
        if (reset) begin
            m_out = 0; m_wrap = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (ifc.load) begin
                m_out = (ld < lim) ? ld : lim;
            end else if (ifc.en && ifc.up_down) begin
                if (m_out < lim) m_out = m_out + 1;
                else begin ev_o = 1'b1; m_out = (sat != 0) ? lim : 0; end
            end else if (ifc.en) begin
                if (m_out == 0) begin ev_u = 1'b1; m_out = (sat != 0) ? 0 : lim; end
                else m_out = (m_out > lim) ? lim : m_out - 1;
            end
            m_wrap = (ev_o || ev_u) ? 1 : 0;
            m_ovf  = ev_o ? 1 : (ifc.clr_flags ? 0 : m_ovf);
            m_unf  = ev_u ? 1 : (ifc.clr_flags ? 0 : m_unf);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_state(string name, int o, int w, int ov, int un);
        check({name, ".out"},  32'(ifc.out),  32'(o));
        check({name, ".wrap"}, 32'(ifc.wrap), 32'(w));
        check({name, ".ovf"},  32'(ifc.ovf),  32'(ov));
        check({name, ".unf"},  32'(ifc.unf),  32'(un));
    endtask

    // Compare process: DUT against the model shortly after every rising edge.
    always @(posedge clk) begin
        #1;
        check("model.out",  32'(ifc.out),  32'(m_out));
        check("model.wrap", 32'(ifc.wrap), 32'(m_wrap));
        check("model.ovf",  32'(ifc.ovf),  32'(m_ovf));
        check("model.unf",  32'(ifc.unf),  32'(m_unf));
    end

    initial begin
        int seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int sat_seq [4];
        int sat_wrap [4];
        total = 0; bad = 0;
        m_out = 0; m_wrap = 0; m_ovf = 0; m_unf = 0;
        reset = 1'b1;
        ifc.en = 1'b0; ifc.up_down = 1'b0; ifc.load = 1'b0; ifc.load_val = 8'd0;
        ifc.limit = 8'd9; ifc.sat_mode = 1'b0; ifc.clr_flags = 1'b0;
        tick();
        expect_state("reset", 0, 0, 0, 0);

        // count up through the limit of 9
        reset = 1'b0; ifc.en = 1'b1; ifc.up_down = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("up9.out",  32'(ifc.out),  32'(seq[i]));
            check("up9.wrap", 32'(ifc.wrap), (i == 9) ? 32'd1 : 32'd0);
        end
        check("up9.ovf", 32'(ifc.ovf), 32'd1);

        // down from 0 wraps to limit, then clear flags
        ifc.load = 1'b1; ifc.load_val = 8'd0; ifc.en = 1'b0;
        tick();
        expect_state("load0", 0, 0, 1, 0);
        ifc.load = 1'b0; ifc.en = 1'b1; ifc.up_down = 1'b0;
        tick();
        expect_state("down0", 9, 1, 1, 1);
        ifc.en = 1'b0; ifc.clr_flags = 1'b1;
        tick();
        expect_state("clr", 9, 0, 0, 0);
        ifc.clr_flags = 1'b0;

        // approach limit 200 from 198 (saturate when available)
`ifdef UDC_SATURATE_EN
        sat_seq = '{199, 200, 200, 200}; sat_wrap = '{0, 0, 1, 1};
`else
        sat_seq = '{199, 200, 0, 1};     sat_wrap = '{0, 0, 1, 0};
`endif
        ifc.sat_mode = 1'b1; ifc.limit = 8'd200; ifc.load_val = 8'd198; ifc.load = 1'b1;
        tick();
        check("ld198.out", 32'(ifc.out), 32'd198);
        ifc.load = 1'b0; ifc.en = 1'b1; ifc.up_down = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sat.out",  32'(ifc.out),  32'(sat_seq[i]));
            check("sat.wrap", 32'(ifc.wrap), 32'(sat_wrap[i]));
        end
        check("sat.ovf", 32'(ifc.ovf), 32'd1);
        ifc.sat_mode = 1'b0;

        // load clipped to limit, then limit lowered under the count
        ifc.en = 1'b0; ifc.load = 1'b1; ifc.load_val = 8'd50; ifc.limit = 8'd20; ifc.clr_flags = 1'b1;
        tick();
        expect_state("ldclip", 20, 0, 0, 0);
        ifc.clr_flags = 1'b0; ifc.load = 1'b0; ifc.limit = 8'd10; ifc.en = 1'b1; ifc.up_down = 1'b0;
        tick();
        expect_state("lower1", 10, 0, 0, 0);
        tick();
        expect_state("lower2", 9, 0, 0, 0);

        // load beats en; limit 0 flags; reset beats load
        ifc.load = 1'b1; ifc.load_val = 8'd5; ifc.limit = 8'd20; ifc.up_down = 1'b1;
        tick();
        expect_state("ld_en", 5, 0, 0, 0);
        ifc.load = 1'b0; ifc.limit = 8'd0;
        tick();
        expect_state("lim0", 0, 1, 1, 0);
        reset = 1'b1; ifc.load = 1'b1;
        tick();
        expect_state("rst_ld", 0, 0, 0, 0);
        reset = 1'b0;

        // set beats clear at the limit
        ifc.limit = 8'd3; ifc.load_val = 8'd3; ifc.load = 1'b1; ifc.en = 1'b0;
        tick();
        ifc.load = 1'b0; ifc.en = 1'b1; ifc.up_down = 1'b1; ifc.clr_flags = 1'b1;
        tick();
        expect_state("setwins", 0, 1, 1, 0);
        ifc.clr_flags = 1'b0;

        // random traffic, checked by the compare process
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 99) == 0);
            ifc.load      = ($urandom_range(0, 9) == 0);
            ifc.en        = ($urandom_range(0, 3) != 0);
            ifc.up_down   = $urandom_range(0, 1);
            ifc.sat_mode  = $urandom_range(0, 1);
            ifc.clr_flags = ($urandom_range(0, 15) == 0);
            ifc.load_val  = WIDTH'($urandom_range(0, MAXV));
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0:       ifc.limit = WIDTH'($urandom_range(0, 3));
                    1:       ifc.limit = WIDTH'($urandom_range(0, 15));
                    default: ifc.limit = WIDTH'($urandom_range(0, MAXV));
                endcase
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
